// File: rtl/iter_cla.sv
`timescale 1ns/1ps
// iter_cla: iterative CHUNK-bit carry-lookahead add/sub over WIDTH-bit operands.
// Ports: clk, rst (async high); in_valid/in_ready + a, b, cin, sub;
// out_valid/out_ready + sum, cout, ovf. Optional zero port with CLA_ZERO_FLAG_EN.
module iter_cla #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
`ifdef CLA_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [KW-1:0]    k_q, k_d;
`ifdef CLA_ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    logic [CHUNK-1:0] sa, sb, sg, sp, ss;
    logic [CHUNK:0]   cc;

    always_comb begin
        sa = a_q[int'(k_q)*CHUNK +: CHUNK];
        sb = b_q[int'(k_q)*CHUNK +: CHUNK];
        sg = sa & sb;
        sp = sa ^ sb;
    end

    // Flat lookahead: each carry is an OR of generate terms masked by
    // the propagate run above them, with no ripple through cc itself.
    always_comb begin : cla
        logic t;
        logic pp;
        t  = 1'b0;
        pp = 1'b0;
        cc = '0;
        cc[0] = c_q;
        for (int i = 0; i < CHUNK; i++) begin
            t  = sg[i];
            pp = sp[i];
            for (int j = i - 1; j >= 0; j--) begin
                t  = t | (pp & sg[j]);
                pp = pp & sp[j];
            end
            cc[i+1] = t | (pp & c_q);
        end
        ss = sp ^ cc[CHUNK-1:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        c_d     = c_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        k_d     = k_q;
`ifdef CLA_ZERO_FLAG_EN
        zero_d  = zero_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? ~cin : cin;
                    k_d     = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[int'(k_q)*CHUNK +: CHUNK] = ss;
                c_d = cc[CHUNK];
                k_d = k_q + KW'(1);
                if (k_q == KLAST) begin
                    cout_d  = cc[CHUNK];
                    // carry into the MSB vs carry out of it
                    ovf_d   = cc[CHUNK-1] ^ cc[CHUNK];
                    k_d     = '0;
                    state_d = DONE;
`ifdef CLA_ZERO_FLAG_EN
                    zero_d  = (sum_d == '0);
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            k_q     <= '0;
`ifdef CLA_ZERO_FLAG_EN
            zero_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            k_q     <= k_d;
`ifdef CLA_ZERO_FLAG_EN
            zero_q  <= zero_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
`ifdef CLA_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_iter_cla.sv
`timescale 1ns/1ps
// tb_iter_cla: directed vectors on three iter_cla configurations
// (32/8, 16/16, 12/1) plus backpressure and mid-RUN reset sequences.
module tb_iter_cla;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_bus, b_bus;
    logic        cin_bus, sub_bus;
    logic [2:0]  iv, ir, ov, ordy, co, of;
    logic [31:0] s0;
    logic [15:0] s1;
    logic [11:0] s2;
`ifdef CLA_ZERO_FLAG_EN
    logic [2:0]  zf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    iter_cla #(.WIDTH(32), .CHUNK(8)) u0 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_bus), .b(b_bus), .cin(cin_bus), .sub(sub_bus),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(s0), .cout(co[0]), .ovf(of[0])
`ifdef CLA_ZERO_FLAG_EN
        , .zero(zf[0])
`endif
    );

    iter_cla #(.WIDTH(16), .CHUNK(16)) u1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_bus[15:0]), .b(b_bus[15:0]), .cin(cin_bus), .sub(sub_bus),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(s1), .cout(co[1]), .ovf(of[1])
`ifdef CLA_ZERO_FLAG_EN
        , .zero(zf[1])
`endif
    );

    iter_cla #(.WIDTH(12), .CHUNK(1)) u2 (
        .clk(clk), .rst(rst),
        .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_bus[11:0]), .b(b_bus[11:0]), .cin(cin_bus), .sub(sub_bus),
        .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(s2), .cout(co[2]), .ovf(of[2])
`ifdef CLA_ZERO_FLAG_EN
        , .zero(zf[2])
`endif
    );

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        su;
        logic [31:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];
    int   nlat [3];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic get_out(input int sel, output logic [31:0] s,
                           output logic c, output logic o, output logic z);
        z = 1'b0;
        case (sel)
            0: s = s0;
            1: s = {16'h0, s1};
            default: s = {20'h0, s2};
        endcase
        c = co[sel];
        o = of[sel];
`ifdef CLA_ZERO_FLAG_EN
        z = zf[sel];
`endif
    endtask

    task automatic run_op(input int sel, input logic [31:0] a,
                          input logic [31:0] b, input logic ci,
                          input logic su, output logic [31:0] s,
                          output logic c, output logic o,
                          output logic z, output int lat);
        @(negedge clk);
        a_bus   = a;
        b_bus   = b;
        cin_bus = ci;
        sub_bus = su;
        iv[sel] = 1'b1;
        @(posedge clk);
        #1;
        iv[sel] = 1'b0;
        lat = 0;
        while (!ov[sel] && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!ov[sel]) lat = -1;
        get_out(sel, s, c, o, z);
    endtask

    task automatic handoff(input int sel);
        @(negedge clk);
        ordy[sel] = 1'b1;
        @(posedge clk);
        #1;
        ordy[sel] = 1'b0;
        chk($sformatf("handoff_ready%0d", sel), {31'b0, ir[sel]}, 32'd1);
        chk($sformatf("handoff_valid%0d", sel), {31'b0, ov[sel]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] s;
        logic        c, o, z;
        int          lat;

        nlat = '{4, 1, 12};
        vecs[0]  = '{0, 32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0};
        vecs[1]  = '{0, 32'hFFFFFFFF, 32'h00000000, 1, 0, 32'h00000000, 1, 0};
        vecs[2]  = '{0, 32'h7FFFFFFF, 32'h00000001, 0, 0, 32'h80000000, 0, 1};
        vecs[3]  = '{0, 32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 1, 1};
        vecs[4]  = '{0, 32'h00000005, 32'h00000007, 0, 1, 32'hFFFFFFFE, 0, 0};
        vecs[5]  = '{0, 32'h00000007, 32'h00000005, 0, 1, 32'h00000002, 1, 0};
        vecs[6]  = '{0, 32'h00000007, 32'h00000005, 1, 1, 32'h00000001, 1, 0};
        vecs[7]  = '{0, 32'h80000000, 32'h00000001, 0, 1, 32'h7FFFFFFF, 1, 1};
        vecs[8]  = '{0, 32'h00000001, 32'h00000002, 0, 0, 32'h00000003, 0, 0};
        vecs[9]  = '{1, 32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0};
        vecs[10] = '{1, 32'h0000FFFF, 32'h00000000, 1, 0, 32'h00000000, 1, 0};
        vecs[11] = '{1, 32'h00007FFF, 32'h00000001, 0, 0, 32'h00008000, 0, 1};
        vecs[12] = '{1, 32'h00008000, 32'h00008000, 0, 0, 32'h00000000, 1, 1};
        vecs[13] = '{1, 32'h00000005, 32'h00000007, 0, 1, 32'h0000FFFE, 0, 0};
        vecs[14] = '{1, 32'h00000007, 32'h00000005, 1, 1, 32'h00000001, 1, 0};
        vecs[15] = '{2, 32'h000000FF, 32'h00000001, 0, 0, 32'h00000100, 0, 0};
        vecs[16] = '{2, 32'h00000FFF, 32'h00000000, 1, 0, 32'h00000000, 1, 0};
        vecs[17] = '{2, 32'h000007FF, 32'h00000001, 0, 0, 32'h00000800, 0, 1};
        vecs[18] = '{2, 32'h00000800, 32'h00000800, 0, 0, 32'h00000000, 1, 1};
        vecs[19] = '{2, 32'h00000005, 32'h00000007, 0, 1, 32'h00000FFE, 0, 0};
        vecs[20] = '{2, 32'h00000007, 32'h00000005, 0, 1, 32'h00000002, 1, 0};

        rst = 1'b1;
        iv = '0;
        ordy = '0;
        a_bus = '0;
        b_bus = '0;
        cin_bus = 1'b0;
        sub_bus = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {29'b0, ir}, 32'h7);
        chk("rst_out_valid", {29'b0, ov}, 32'h0);
        chk("rst_cout", {29'b0, co}, 32'h0);
        chk("rst_ovf", {29'b0, of}, 32'h0);
        chk("rst_sum0", s0, 32'h0);
        chk("rst_sum1", {16'h0, s1}, 32'h0);
        chk("rst_sum2", {20'h0, s2}, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].sel, vecs[i].a, vecs[i].b, vecs[i].ci,
                   vecs[i].su, s, c, o, z, lat);
            chk($sformatf("v%0d_sum", i), s, vecs[i].s);
            chk($sformatf("v%0d_cout", i), {31'b0, c}, {31'b0, vecs[i].co});
            chk($sformatf("v%0d_ovf", i), {31'b0, o}, {31'b0, vecs[i].ov});
            chk($sformatf("v%0d_lat", i), lat, nlat[vecs[i].sel]);
`ifdef CLA_ZERO_FLAG_EN
            chk($sformatf("v%0d_zero", i), {31'b0, z},
                {31'b0, vecs[i].s == 32'h0});
`endif
            handoff(vecs[i].sel);
        end

        // backpressure: DONE holds, new operands ignored, even at handoff
        run_op(0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, s, c, o, z, lat);
        chk("bp_sum", s, 32'h80000000);
        @(negedge clk);
        a_bus = 32'h12345678;
        b_bus = 32'h11111111;
        iv[0] = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            chk("bp_valid", {31'b0, ov[0]}, 32'd1);
            chk("bp_ready", {31'b0, ir[0]}, 32'd0);
            chk("bp_hold_sum", s0, 32'h80000000);
            chk("bp_hold_cout", {31'b0, co[0]}, 32'd0);
            chk("bp_hold_ovf", {31'b0, of[0]}, 32'd1);
        end
        @(negedge clk);
        ordy[0] = 1'b1;
        @(posedge clk);
        #1;
        ordy[0] = 1'b0;
        iv[0] = 1'b0;
        chk("bp_idle_ready", {31'b0, ir[0]}, 32'd1);
        chk("bp_idle_valid", {31'b0, ov[0]}, 32'd0);
        run_op(0, 32'h5, 32'h7, 1'b0, 1'b1, s, c, o, z, lat);
        chk("bp_next_sum", s, 32'hFFFFFFFE);
        chk("bp_next_cout", {31'b0, c}, 32'd0);
        handoff(0);

        // async reset two cycles into RUN
        @(negedge clk);
        a_bus = 32'h11111111;
        b_bus = 32'h22222222;
        cin_bus = 1'b0;
        sub_bus = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid_partial", s0, 32'h00003333);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, ov[0]}, 32'd0);
        chk("mid_rst_sum", s0, 32'h0);
        chk("mid_rst_ready", {31'b0, ir[0]}, 32'd1);
        chk("mid_rst_cout", {31'b0, co[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op(0, 32'h1, 32'h2, 1'b0, 1'b0, s, c, o, z, lat);
        chk("post_rst_sum", s, 32'h3);
        chk("post_rst_lat", lat, 32'd4);
        handoff(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iter_cla.md
# iter_cla

Iterative, parametrised carry-lookahead adder/subtractor. It adds or subtracts two WIDTH-bit operands in CHUNK-bit slices, one slice per clock, using a CHUNK-bit CLA and a registered inter-slice carry. Operands enter and results leave through valid/ready handshakes. It is the sequential, width-generic successor to the fixed 32-bit combinational CLA, for wide datapaths where a full-width lookahead tree would not meet timing.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 8, bits added per cycle; CHUNK ≥ 1. NCHUNK = WIDTH/CHUNK.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  operands and mode are valid.
- in_ready  output  1  block can accept operands; high only in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result is valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result, registered.
- cout  output  1  final carry-out; in subtract mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready:
    - Latch A = a, B' = sub ? ~b : b.
    - Latch carry c = sub ? ~cin : cin.
    - Clear slice index k = 0 and the sum register.
    - Go to RUN.
- Arithmetic: add computes a + b + cin. Subtract computes a − b − cin as a + ~b + ~cin.
- RUN, each cycle:
  - Compute {c_next, s} = A[k·CHUNK +: CHUNK] + B'[k·CHUNK +: CHUNK] + c, using CHUNK-bit lookahead generate/propagate.
  - Write s into sum[k·CHUNK +: CHUNK], set c = c_next, increment k.
  - When k = NCHUNK−1:
    - Latch cout = c_next.
    - Latch ovf = (carry into bit WIDTH−1) XOR c_next.
    - Go to DONE.
- DONE:
  - out_valid = 1; sum, cout and ovf are held stable.
  - On out_ready, go to IDLE.
  - in_ready = 0, so no new operands are accepted in the same cycle as the result handoff.
- Operands on a, b, cin and sub are ignored outside IDLE.
- The partial sum is not visible as valid while in RUN.
- NCHUNK = 1: RUN lasts one cycle, then DONE.

## Timing
- Reset values: in_ready = 1, out_valid = 0, sum = 0, cout = 0, ovf = 0. Internal k = 0, c = 0.
- Accept at edge T. Slices 0..NCHUNK−1 are computed at edges T+1..T+NCHUNK. out_valid goes high after edge T+NCHUNK.
- Latency from accept to out_valid is NCHUNK cycles. Throughput is one operation per NCHUNK+2 cycles at best (accept, NCHUNK RUN cycles, result handoff).
- in_ready and out_valid are decoded from registered state, with no combinational path from inputs.
- Backpressure: with out_ready held low, DONE holds indefinitely and outputs do not change.
- rst asserted in any state, including mid-RUN or DONE:
  - Immediate return to IDLE with all outputs at reset values.
  - The in-flight operation is discarded.
  - The first accept after rst deasserts behaves normally.

## Configuration
- Macro: CLA_ZERO_FLAG_EN.
- Defined:
  - Adds output port zero (1 bit, reset 0).
  - zero is registered on the DONE transition and equals (final sum == 0).
  - It is valid while out_valid is high and held with the other outputs.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
All scenarios use WIDTH=32, CHUNK=8 unless stated.
- a=0x000000FF, b=0x00000001, cin=0, sub=0 → sum=0x00000100, cout=0, ovf=0. out_valid rises exactly 4 cycles after accept.
- a=0xFFFFFFFF, b=0x00000000, cin=1, sub=0 → sum=0x00000000, cout=1, ovf=0. The carry ripples through all slices; zero=1 when CLA_ZERO_FLAG_EN is defined.
- a=0x7FFFFFFF, b=0x00000001, sub=0 → sum=0x80000000, ovf=1, cout=0. a=0x80000000, b=0x80000000 → sum=0, ovf=1, cout=1.
- Subtract, sub=1, cin=0:
  - a=5, b=7 → sum=0xFFFFFFFE, cout=0.
  - a=7, b=5 → sum=0x00000002, cout=1.
  - a=7, b=5, cin=1 → sum=0x00000001.
- Hold out_ready=0 for 10 cycles in DONE → out_valid=1, sum/cout/ovf constant, in_ready=0. Then raise out_ready → IDLE next cycle, and the next operation is correct.
- Assert rst 2 cycles into RUN → out_valid=0, sum=0, in_ready=1 immediately. Then run a=1, b=2 → sum=3. Repeat the directed cases with WIDTH=16, CHUNK=16 (1-cycle latency) and WIDTH=12, CHUNK=1 (12-cycle latency).
